// File: rtl/fast_writeback_buffer_if.sv
// Decoder-lane write port and drain stream of the FAST field write-back buffer.
// The master side is the decoder / order-book glue; the slave side is the buffer itself.
interface fast_writeback_buffer_if #(
    parameter int unsigned beat_width       = 64,
    parameter int unsigned max_message_size = 10,
    parameter int unsigned sup_paths        = 4,
    parameter int unsigned messageID_size   = 21
);
    localparam int unsigned iw = $clog2(max_message_size);

    logic [0:sup_paths-1]                     in_valid;
    logic [sup_paths-1:0][messageID_size-1:0] in_msg_id;
    logic [sup_paths-1:0][iw-1:0]             in_field_idx;
    logic [sup_paths-1:0][beat_width-1:0]     in_field;
    logic                                     in_ready;
    logic                                     msg_close;
    logic [iw:0]                              msg_field_count;

    logic                                     out_valid;
    logic                                     out_ready;
    logic [beat_width-1:0]                    out_field;
    logic [iw-1:0]                            out_field_idx;
    logic [messageID_size-1:0]                out_msg_id;
    logic                                     out_present;
    logic                                     out_last;

    logic                                     collision_err;
    logic                                     id_err;
    logic                                     idx_err;

    modport master (
        output in_valid, in_msg_id, in_field_idx, in_field, msg_close, msg_field_count,
        output out_ready,
        input  in_ready,
        input  out_valid, out_field, out_field_idx, out_msg_id, out_present, out_last,
        input  collision_err, id_err, idx_err
    );

    modport slave (
        input  in_valid, in_msg_id, in_field_idx, in_field, msg_close, msg_field_count,
        input  out_ready,
        output in_ready,
        output out_valid, out_field, out_field_idx, out_msg_id, out_present, out_last,
        output collision_err, id_err, idx_err
    );
endinterface

// File: rtl/fast_writeback_buffer.sv
// Registered FAST field write-back buffer: collects decoded fields from the decoder lanes
// by index, then drains the assembled message in index order over a valid/ready stream.
module fast_writeback_buffer #(
    parameter int unsigned beat_width       = 64,
    parameter int unsigned max_message_size = 10,
    parameter int unsigned sup_paths        = 4,
    parameter int unsigned messageID_size   = 21
) (
    input logic                   clk,
    input logic                   rst,
    fast_writeback_buffer_if.slave bus
);
    localparam int unsigned iw = $clog2(max_message_size);
    localparam logic [iw:0] max_cnt = (iw + 1)'(max_message_size);

    localparam logic [0:0] StCollect = 1'b0;
    localparam logic [0:0] StDrain   = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [beat_width-1:0]     field_buf_q [max_message_size];
    logic [max_message_size-1:0] present_q, present_d;
    logic                      id_valid_q, id_valid_d;
    logic [messageID_size-1:0] id_q, id_d;
    logic [iw:0]               count_q, count_d;
    logic [iw-1:0]             idx_q, idx_d;
    logic                      collision_q, id_err_q, idx_err_q;

    logic                      collect;
    logic                      drain;
    logic                      last_beat;
    logic [iw:0]               cnt_clamp;

    logic [max_message_size-1:0] wen;
    logic [beat_width-1:0]     wdata [max_message_size];
    logic                      id_found;
    logic [messageID_size-1:0] eff_id;
    logic                      coll_hit;
    logic                      id_bad;
    logic                      idx_bad;

    assign collect   = (state_q == StCollect);
    assign drain     = (state_q == StDrain);
    assign last_beat = ({1'b0, idx_q} == (count_q - 1'b1));
    assign cnt_clamp = (bus.msg_field_count > max_cnt) ? max_cnt : bus.msg_field_count;

    // Lane decode: ID resolution first, then lanes in ascending order so the highest lane wins.
    always_comb begin
        wen      = '0;
        coll_hit = 1'b0;
        id_bad   = 1'b0;
        idx_bad  = 1'b0;
        id_found = id_valid_q;
        eff_id   = id_q;
        for (int j = 0; j < max_message_size; j++) begin
            wdata[j] = '0;
        end
        for (int k = 0; k < sup_paths; k++) begin
            if (!id_found && bus.in_valid[k] && ({1'b0, bus.in_field_idx[k]} < max_cnt)) begin
                id_found = 1'b1;
                eff_id   = bus.in_msg_id[k];
            end
        end
        for (int k = 0; k < sup_paths; k++) begin
            if (collect && bus.in_valid[k]) begin
                if ({1'b0, bus.in_field_idx[k]} >= max_cnt) begin
                    idx_bad = 1'b1;
                end else if (bus.in_msg_id[k] != eff_id) begin
                    id_bad = 1'b1;
                end else begin
                    if (wen[bus.in_field_idx[k]] || present_q[bus.in_field_idx[k]]) begin
                        coll_hit = 1'b1;
                    end
                    wen[bus.in_field_idx[k]]   = 1'b1;
                    wdata[bus.in_field_idx[k]] = bus.in_field[k];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        present_d  = present_q;
        id_valid_d = id_valid_q;
        id_d       = id_q;
        count_d    = count_q;
        idx_d      = idx_q;
        if (collect) begin
            present_d = present_q | wen;
            if (id_found) begin
                id_valid_d = 1'b1;
                id_d       = eff_id;
            end
            if (bus.msg_close) begin
                count_d = cnt_clamp;
                if (cnt_clamp == '0) begin
                    present_d  = '0;
                    id_valid_d = 1'b0;
                    id_d       = '0;
                end else begin
                    state_d = StDrain;
                    idx_d   = '0;
                end
            end
        end else if (bus.out_ready) begin
            if (last_beat) begin
                state_d    = StCollect;
                present_d  = '0;
                id_valid_d = 1'b0;
                id_d       = '0;
                idx_d      = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StCollect;
            present_q   <= '0;
            id_valid_q  <= 1'b0;
            id_q        <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            collision_q <= 1'b0;
            id_err_q    <= 1'b0;
            idx_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            present_q   <= present_d;
            id_valid_q  <= id_valid_d;
            id_q        <= id_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            collision_q <= coll_hit;
            id_err_q    <= id_bad;
            idx_err_q   <= idx_bad;
        end
    end

    // Field storage is qualified by present_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < max_message_size; j++) begin
            if (wen[j]) begin
                field_buf_q[j] <= wdata[j];
            end
        end
    end

    assign bus.in_ready      = collect;
    assign bus.out_valid     = drain;
    assign bus.out_present   = drain && present_q[idx_q];
    assign bus.out_field     = (drain && present_q[idx_q]) ? field_buf_q[idx_q] : '0;
    assign bus.out_field_idx = drain ? idx_q : '0;
    assign bus.out_msg_id    = drain ? id_q : '0;
    assign bus.out_last      = drain && last_beat;
    assign bus.collision_err = collision_q;
    assign bus.id_err        = id_err_q;
    assign bus.idx_err       = idx_err_q;
endmodule

// File: doc/fast_writeback_buffer.md
# fast_writeback_buffer

Registered successor to the combinational FAST field write-back stage. It accepts up to `sup_paths` decoded fields per cycle from the superscalar decoder lanes and stores them by field index into a per-message field buffer. It tracks which fields are present and flags collisions and foreign message IDs. On message close it drains the assembled message in index order over a valid/ready stream toward the order-book update logic.

## Interface
- `beat_width`, 64, field value width in bits
- `max_message_size`, 10, buffer depth (fields per message); IW = $clog2(max_message_size)
- `sup_paths`, 4, number of decoder write lanes
- `messageID_size`, 21, message/template ID width
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  [0:sup_paths-1]  per-lane write request
- `in_msg_id`  in  messageID_size x sup_paths  message ID per lane
- `in_field_idx`  in  IW x sup_paths  target field index per lane
- `in_field`  in  beat_width x sup_paths  decoded field value per lane
- `in_ready`  out  1  shared by all lanes; a lane write is accepted when `in_valid[k] && in_ready`
- `msg_close`  in  1  end of current message; accepted when `in_ready`
- `msg_field_count`  in  IW+1  number of fields to drain, 0..max_message_size
- `out_valid`  out  1  drain beat valid
- `out_ready`  in  1  downstream ready
- `out_field`  out  beat_width  field value (zero if not present)
- `out_field_idx`  out  IW  index of the beat
- `out_msg_id`  out  messageID_size  latched message ID
- `out_present`  out  1  field was written during this message
- `out_last`  out  1  final beat of the message
- `collision_err`  out  1  one-cycle pulse
- `id_err`  out  1  one-cycle pulse
- `idx_err`  out  1  one-cycle pulse

## Operation
- States: COLLECT (`in_ready`=1, `out_valid`=0) and DRAIN (`in_ready`=0, `out_valid`=1).
- COLLECT, per accepted lane k:
  - If `in_field_idx[k]` >= max_message_size: drop the write and pulse `idx_err`.
  - Else if an ID is latched and `in_msg_id[k]` differs: drop the write and pulse `id_err`.
  - Else write `buf[idx]`, set `present[idx]`.
- ID latching: the first valid write after empty/reset latches its ID. If several lanes write in that same cycle, the lowest-numbered valid lane with an in-range index sets the ID. The other lanes are checked against it in the same cycle.
- Collisions: two or more accepted lanes targeting the same index in one cycle resolve as highest lane index wins. A write to an index whose `present` bit is already set overwrites it. Either case pulses `collision_err` once for that cycle.
- `msg_close` in COLLECT:
  - Same-cycle lane writes are applied first.
  - The count is latched, clamped to max_message_size.
  - If count = 0: clear `present` and the ID latch, and stay in COLLECT.
  - Else move to DRAIN with the drain index at 0.
- DRAIN:
  - Present `buf[i]` (or 0 if not present), `present[i]`, `i`, and the latched ID.
  - `out_last` = (i == count-1).
  - On `out_valid && out_ready`, advance i.
  - On the handshake of the last beat: clear `present`, clear the ID latch, and return to COLLECT.
- Outputs are stable while `out_valid && !out_ready`.
- Error pulses are registered and assert the cycle after the offending write.

## Timing
- Reset (async, any state, mid-drain included):
  - State = COLLECT, `present` = 0, ID latch empty.
  - `in_ready`=1; `out_valid`=0, `out_last`=0, `out_present`=0.
  - `out_field`, `out_field_idx`, `out_msg_id` = 0; all error pulses = 0.
  - Buffer contents need not be reset.
- Write latency: 1 cycle. A write in cycle N is visible to a drain starting in cycle N+1.
- Close in cycle N: `out_valid`=1 and `in_ready`=0 from N+1. A close with count=0 leaves `in_ready`=1 throughout.
- Drain throughput is 1 beat/cycle with `out_ready` held high, so count C takes C cycles.
- After the last beat is accepted in cycle M, `in_ready`=1 in M+1.
- `in_valid` and `msg_close` asserted during DRAIN are ignored (not accepted).

## Test plan
- Lanes 0..3 write ID 5 to idx 0..3 (values 0xA0..0xA3) in one cycle, then close with count 4 and `out_ready`=1.
  - Expect 4 beats idx 0..3, values 0xA0..0xA3, `out_present`=1, `out_msg_id`=5, `out_last` on idx 3.
- Lanes 1 and 3 write idx 2 with 0x11 and 0x33 in the same cycle, then close with count 3.
  - Expect `collision_err` pulse; beat idx 2 = 0x33.
  - Beats idx 0 and 1 have `out_present`=0 and `out_field`=0.
- Lane 0 writes ID 7 idx 0 while lane 1 writes ID 9 idx 1; lane 2 writes idx 12.
  - Expect `id_err` and `idx_err` pulses; only idx 0 is stored.
- Drain 5 beats with `out_ready` toggling 1,0,0,1,...
  - Outputs hold during stall cycles; `in_ready` stays 0 until the cycle after the idx 4 handshake.
- Close with count 0, then close with count 15 (clamped to 10).
  - First close: no beats, `in_ready` stays 1.
  - Second close: 10 beats, idx 0..9.
- Assert `rst` during the third beat of a drain.
  - Expect `out_valid`=0 and `in_ready`=1 immediately.
  - A following count-1 message drains with `present` showing only the new write.
